// File: rtl/tern_host_driver_pkg.sv
// Package tern_drv_pkg: shared types and sizing helpers for the ternary
// matmul host driver.
//   state_e      - driver FSM states
//   WEIGHT_WIDTH - bits per ternary weight
//   PIN_WIDTH    - width of the chip input bus {ui_in,uio_in}
//   idx_w/cnt_w  - index / cycle-counter width helpers
package tern_drv_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_LOAD, S_MULT} state_e;

  localparam int WEIGHT_WIDTH = 2;
  localparam int PIN_WIDTH    = 16;

  // Bits needed to index n entries; never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter wide enough for the longest phase (reset, load, frame).
  function automatic int cnt_w(input int rst_cyc, input int load_cyc, input int frame_cyc);
    int m;
    m = rst_cyc;
    if (load_cyc > m) m = load_cyc;
    if (frame_cyc > m) m = frame_cyc;
    return idx_w(m);
  endfunction

endpackage

// File: rtl/tern_host_driver_if.sv
// Interface tern_host_driver_if: every bus-level signal of the host driver.
//   control : start_i, stop_i, wt_i, busy
//   stream  : act_valid/act_ready/act_data (activation vectors in)
//   chip    : drv_rst_n, pin_o (to chip), dut_uo (from chip)
//   result  : res_valid/res_data (captured uo_out per real frame)
// Modports: slave = the driver itself, master = harness driving it.
interface tern_host_driver_if #(
  parameter int IN_LEN    = 12,
  parameter int OUT_LEN   = 7,
  parameter int BIT_WIDTH = 8
);
  import tern_drv_pkg::*;

  logic                                  start_i;
  logic                                  stop_i;
  logic [WEIGHT_WIDTH*IN_LEN*OUT_LEN-1:0] wt_i;
  logic                                  act_valid;
  logic                                  act_ready;
  logic [IN_LEN*BIT_WIDTH-1:0]           act_data;
  logic                                  drv_rst_n;
  logic [PIN_WIDTH-1:0]                  pin_o;
  logic [7:0]                            dut_uo;
  logic                                  res_valid;
  logic [OUT_LEN*BIT_WIDTH-1:0]          res_data;
  logic                                  busy;

  modport slave (
    input  start_i, stop_i, wt_i, act_valid, act_data, dut_uo,
    output act_ready, drv_rst_n, pin_o, res_valid, res_data, busy
  );

  modport master (
    output start_i, stop_i, wt_i, act_valid, act_data, dut_uo,
    input  act_ready, drv_rst_n, pin_o, res_valid, res_data, busy
  );

endinterface

// File: rtl/tern_host_driver_capture.sv
// Module tern_resp_capture: collects the chip's uo_out for each real MULT frame.
//   clk, rst_n  - clock, synchronous active-low reset
//   tag_real    - next pin cycle carries a real frame bit (registered here,
//                 so stage 0 lines up with pin_o)
//   tag_idx     - frame-cycle index of that pin cycle
//   dut_uo      - chip uo_out
//   res_valid   - one-cycle pulse after the last sample of a real frame
//   res_data    - uo_out[k] of frame cycle c at [k*BIT_WIDTH+c]
module tern_resp_capture
  import tern_drv_pkg::*;
#(
  parameter int OUT_LEN   = 7,
  parameter int BIT_WIDTH = 8,
  parameter int RESP_LAT  = 1,
  localparam int BI       = idx_w(BIT_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tag_real,
  input  logic [BI-1:0]                tag_idx,
  input  logic [7:0]                   dut_uo,
  output logic                         res_valid,
  output logic [OUT_LEN*BIT_WIDTH-1:0] res_data
);

  // Stage 0 is aligned with the driven pins; stage RESP_LAT with the response.
  logic [RESP_LAT:0]                  vld_pipe;
  logic [RESP_LAT:0][BI-1:0]          idx_pipe;
  logic [OUT_LEN-1:0][BIT_WIDTH-1:0]  cap_q, cap_n, res_q;
  logic                               res_vld_q;
  logic                               smp_vld, smp_last;
  logic [BI-1:0]                      smp_idx;
  logic                               unused_uo;

  assign smp_vld  = vld_pipe[RESP_LAT];
  assign smp_idx  = idx_pipe[RESP_LAT];
  assign smp_last = smp_vld && (smp_idx == BI'(BIT_WIDTH-1));
  // Only the low OUT_LEN uo_out bits carry results.
  assign unused_uo = ^{1'b0, dut_uo};

  always_comb begin
    cap_n = cap_q;
    if (smp_vld)
      for (int k = 0; k < OUT_LEN; k++) cap_n[k][smp_idx] = dut_uo[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      cap_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      vld_pipe[0] <= tag_real;
      idx_pipe[0] <= tag_idx;
      for (int i = 1; i <= RESP_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      cap_q     <= cap_n;
      res_vld_q <= smp_last;
      if (smp_last) res_q <= cap_n;
    end
  end

  assign res_valid = res_vld_q;
  assign res_data  = res_q;

endmodule

// File: rtl/tern_host_driver.sv
// Module tern_host_driver: host-side transmitter for the ternary matmul pin
// protocol. Resets the chip, streams weights (LOAD), then one bit-serial
// activation vector per BIT_WIDTH-cycle MULT frame, in lock-step with the
// chip's free-running counter. Frames with no vector are sent as zero bubbles.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - tern_host_driver_if.slave (control, stream, chip, result)
// Build option: TERN_DRV_CAPTURE_EN enables uo_out capture (res_valid/res_data);
// without it both results are tied to zero and dut_uo is ignored.
module tern_host_driver
  import tern_drv_pkg::*;
#(
  parameter int IN_LEN    = 12,
  parameter int OUT_LEN   = 7,
  parameter int BIT_WIDTH = 8,
  parameter int RST_CYC   = 2,
  parameter int RESP_LAT  = 1
) (
  input logic              clk,
  input logic              rst_n,
  tern_host_driver_if.slave bus
);

  localparam int NWORD = WEIGHT_WIDTH * OUT_LEN;
  localparam int CW    = cnt_w(RST_CYC, NWORD, BIT_WIDTH);
  localparam int BI    = idx_w(BIT_WIDTH);
  localparam int WI    = idx_w(NWORD);

  state_e                            state_q, state_n;
  logic [CW-1:0]                     cnt_q, cnt_n;
  logic                              stop_q, stop_n;
  logic [NWORD-1:0][IN_LEN-1:0]      wt_q, wt_n;
  logic [IN_LEN-1:0][BIT_WIDTH-1:0]  abuf_q, abuf_n;
  logic                              real_q, real_n;
  logic                              drv_q, drv_n;
  logic [PIN_WIDTH-1:0]              pin_q, pin_n;
  logic                              rdy_q, rdy_n;
  logic                              busy_q, busy_n;
  logic                              hs, stop_req;

  assign hs       = bus.act_valid && rdy_q;
  assign stop_req = stop_q || bus.stop_i;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CW'(1);
    stop_n  = stop_q;
    wt_n    = wt_q;
    abuf_n  = abuf_q;
    real_n  = real_q;
    pin_n   = '0;

    case (state_q)
      S_IDLE: begin
        cnt_n  = '0;
        stop_n = 1'b0;
        if (bus.start_i) begin
          wt_n    = bus.wt_i;
          state_n = S_RST;
        end
      end
      S_RST: begin
        if (stop_req) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(RST_CYC-1)) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        if (stop_req) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(NWORD-1)) begin
          state_n = S_MULT;
          cnt_n   = '0;
        end
      end
      S_MULT: begin
        stop_n = stop_req;
        if (cnt_q == CW'(BIT_WIDTH-1)) begin
          cnt_n = '0;
          // A vector accepted on this boundary still gets its frame; the
          // pending stop then lands on the following boundary.
          if (stop_req && !hs) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Frame buffer is (re)loaded exactly at each frame start.
    if (state_n == S_MULT && cnt_n == '0) begin
      real_n = hs;
      if (hs) abuf_n = bus.act_data;
    end

    // Registered outputs are derived from the next state so they line up
    // with state_q/cnt_q in the cycle they are visible.
    if (state_n == S_LOAD)
      pin_n[IN_LEN-1:0] = wt_q[cnt_n[WI-1:0]];
    else if (state_n == S_MULT)
      for (int j = 0; j < IN_LEN; j++) pin_n[j] = real_n & abuf_n[j][cnt_n[BI-1:0]];

    drv_n  = (state_n == S_LOAD) || (state_n == S_MULT);
    rdy_n  = ((state_n == S_LOAD) && (cnt_n == CW'(NWORD-1))) ||
             ((state_n == S_MULT) && (cnt_n == CW'(BIT_WIDTH-1)) && !stop_n);
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      wt_q    <= '0;
      abuf_q  <= '0;
      real_q  <= 1'b0;
      drv_q   <= 1'b0;
      pin_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      stop_q  <= stop_n;
      wt_q    <= wt_n;
      abuf_q  <= abuf_n;
      real_q  <= real_n;
      drv_q   <= drv_n;
      pin_q   <= pin_n;
      rdy_q   <= rdy_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.drv_rst_n = drv_q;
  assign bus.pin_o     = pin_q;
  assign bus.act_ready = rdy_q;
  assign bus.busy      = busy_q;

`ifdef TERN_DRV_CAPTURE_EN
  tern_resp_capture #(
    .OUT_LEN   (OUT_LEN),
    .BIT_WIDTH (BIT_WIDTH),
    .RESP_LAT  (RESP_LAT)
  ) u_cap (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_real  ((state_n == S_MULT) && real_n),
    .tag_idx   (cnt_n[BI-1:0]),
    .dut_uo    (bus.dut_uo),
    .res_valid (bus.res_valid),
    .res_data  (bus.res_data)
  );
`else
  logic unused_uo;
  assign unused_uo     = ^bus.dut_uo;
  assign bus.res_valid = 1'b0;
  assign bus.res_data  = '0;
`endif

endmodule

// File: tb/tb_tern_host_driver.sv
module tb_tern_host_driver;

  localparam int IN_LEN = 12, OUT_LEN = 7, BW = 8, RST_CYC = 2, RESP_LAT = 1;
`ifdef TERN_DRV_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tern_host_driver_if #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .BIT_WIDTH(BW)) bus ();

  tern_host_driver #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .BIT_WIDTH(BW),
    .RST_CYC(RST_CYC), .RESP_LAT(RESP_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Chip stand-in: one-cycle registered loopback of the low pin byte.
  always @(posedge clk) bus.dut_uo <= bus.pin_o[7:0];

  logic [2*IN_LEN*OUT_LEN-1:0] wt;
  logic [IN_LEN*BW-1:0]        vec1, vec3, vec4, zvec;

  function automatic logic [11:0] wword(input int c);
    return 12'h5A0 + 12'(c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at frame cycle 0; returns at cycle 0 of whatever follows.
  task automatic frame(input int id, input logic [IN_LEN*BW-1:0] acts, input bit is_real,
                       input bit pulse, input logic [55:0] res_exp, input bit rdy_last,
                       input bit offer, input logic [IN_LEN*BW-1:0] nxt,
                       input int stop_at, input int start_at);
    logic [15:0] ep;
    bus.act_valid = 1'b0;
    for (int c = 0; c < BW; c++) begin
      ep = '0;
      for (int j = 0; j < IN_LEN; j++) ep[j] = is_real & acts[j*BW+c];
      chk($sformatf("pin f%0d c%0d", id, c), 64'(bus.pin_o), 64'(ep));
      chk($sformatf("res_valid f%0d c%0d", id, c), 64'(bus.res_valid),
          64'(CAP && pulse && c == 1));
      if (c == 1 && pulse)
        chk($sformatf("res_data f%0d", id), 64'(bus.res_data), CAP ? 64'(res_exp) : 64'd0);
      bus.stop_i  = (c == stop_at);
      bus.start_i = (c == start_at);
      if (c == BW-1) begin
        chk($sformatf("act_ready f%0d", id), 64'(bus.act_ready), 64'(rdy_last));
        bus.act_valid = offer;
        bus.act_data  = nxt;
      end
      step();
    end
    bus.stop_i    = 1'b0;
    bus.start_i   = 1'b0;
    bus.act_valid = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 2*OUT_LEN; c++) wt[c*IN_LEN +: IN_LEN] = wword(c);
    zvec = '0;
    vec1 = '0;
    vec1[7:0] = 8'hA5;
    for (int j = 0; j < IN_LEN; j++) begin
      vec3[j*BW +: BW] = 8'(j + 1);
      vec4[j*BW +: BW] = 8'hC0 + 8'(j);
    end

    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.wt_i = '0;
    bus.act_valid = 1'b0; bus.act_data = '0;
    repeat (3) step();
    chk("rst drv_rst_n", 64'(bus.drv_rst_n), 64'd0);
    chk("rst pin_o", 64'(bus.pin_o), 64'd0);
    chk("rst act_ready", 64'(bus.act_ready), 64'd0);
    chk("rst res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst res_data", 64'(bus.res_data), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);

    // stop_i in IDLE does nothing
    rst_n = 1'b1;
    bus.stop_i = 1'b1;
    step();
    bus.stop_i = 1'b0;
    chk("idle stop busy", 64'(bus.busy), 64'd0);

    // start: two reset cycles, then 14 weight words
    bus.start_i = 1'b1;
    bus.wt_i = wt;
    step();
    bus.start_i = 1'b0;
    bus.wt_i = '1;
    chk("rst0 busy", 64'(bus.busy), 64'd1);
    chk("rst0 drv_rst_n", 64'(bus.drv_rst_n), 64'd0);
    chk("rst0 pin_o", 64'(bus.pin_o), 64'd0);
    step();
    chk("rst1 drv_rst_n", 64'(bus.drv_rst_n), 64'd0);
    step();
    for (int c = 0; c < 2*OUT_LEN; c++) begin
      chk($sformatf("load drv_rst_n c%0d", c), 64'(bus.drv_rst_n), 64'd1);
      chk($sformatf("load pin c%0d", c), 64'(bus.pin_o), 64'(wword(c)));
      chk($sformatf("load act_ready c%0d", c), 64'(bus.act_ready), 64'(c == 2*OUT_LEN-1));
      if (c == 2*OUT_LEN-1) begin
        bus.act_valid = 1'b1;
        bus.act_data  = vec1;
      end
      step();
    end

    // frame 1: A5 on act0; frame 2: bubble (start_i ignored mid-run);
    // frame 3: act k = k+1; frame 4: act k = C0+k with stop at cycle 3
    frame(1, vec1, 1'b1, 1'b0, 56'h0, 1'b1, 1'b0, zvec, -1, -1);
    frame(2, zvec, 1'b0, 1'b1, 56'h00_0000_0000_00A5, 1'b1, 1'b1, vec3, -1, 2);
    frame(3, vec3, 1'b1, 1'b0, 56'h0, 1'b1, 1'b1, vec4, -1, -1);
    frame(4, vec4, 1'b1, 1'b1, 56'h07_0605_0403_0201, 1'b0, 1'b0, zvec, 3, -1);

    chk("stop idle busy", 64'(bus.busy), 64'd0);
    chk("stop idle drv_rst_n", 64'(bus.drv_rst_n), 64'd0);
    chk("stop idle pin_o", 64'(bus.pin_o), 64'd0);
    chk("stop idle act_ready", 64'(bus.act_ready), 64'd0);
    chk("stop idle res_valid0", 64'(bus.res_valid), 64'd0);
    step();
    chk("stop idle res_valid1", 64'(bus.res_valid), 64'(CAP));
    chk("stop idle res_data", 64'(bus.res_data), CAP ? 64'h00C6_C5C4_C3C2_C1C0 : 64'd0);
    step();
    chk("stop idle res_valid2", 64'(bus.res_valid), 64'd0);
    chk("stop idle res_hold", 64'(bus.res_data), CAP ? 64'h00C6_C5C4_C3C2_C1C0 : 64'd0);

    // restart, then reset during LOAD cycle 5
    bus.start_i = 1'b1;
    bus.wt_i = wt;
    step();
    bus.start_i = 1'b0;
    repeat (2 + 5) step();
    chk("load5 pin", 64'(bus.pin_o), 64'(wword(5)));
    rst_n = 1'b0;
    step();
    chk("midrst drv_rst_n", 64'(bus.drv_rst_n), 64'd0);
    chk("midrst pin_o", 64'(bus.pin_o), 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst act_ready", 64'(bus.act_ready), 64'd0);

    // start and stop together in IDLE: start wins, load replays from word 0
    rst_n = 1'b1;
    bus.start_i = 1'b1;
    bus.stop_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    chk("replay busy", 64'(bus.busy), 64'd1);
    repeat (2) step();
    chk("replay drv_rst_n", 64'(bus.drv_rst_n), 64'd1);
    chk("replay pin c0", 64'(bus.pin_o), 64'(wword(0)));
    step();
    chk("replay pin c1", 64'(bus.pin_o), 64'(wword(1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
